sha256_padder: RTL

//  Upstream feeder for the SHA-256 message schedule. Accepts the message as a stream of big-endian
//  32-bit words and packs 16 words into each 512-bit block. It applies FIPS 180-4 padding:
//  0x80 byte, zero fill, then the 64-bit bit-length. Blocks are presented with a valid/ready handshake.

---
 rtl/sha256_pkg.sv | 21 ++
 rtl/sha256_pad_word.sv | 24 ++
 rtl/sha256_padder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and helpers for the SHA-256 message padder.
package sha256_pkg;

    localparam int         SHA256_WORD_W      = 32;
    localparam int         SHA256_BLOCK_W     = 512;
    localparam int         SHA256_LEN_W       = 64;
    localparam int         SHA256_BLOCK_WORDS = 16;
    localparam logic [7:0] SHA256_PAD_BYTE    = 8'h80;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        EMIT     = 2'd1,
        EMIT_LEN = 2'd2
    } state_t;

    // Valid byte count of a final word; anything above 4 means a full word.
    function automatic logic [2:0] clamp_bytes(input logic [2:0] bytes);
        return (bytes > 3'd4) ? 3'd4 : bytes;
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Pads one big-endian 32-bit word: keeps the first n bytes, zeroes the rest,
// and when pad_en is set and n<4 places the 0x80 marker at byte n.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [SHA256_WORD_W-1:0] word,
    input  logic [2:0]               n,
    input  logic                     pad_en,
    output logic [SHA256_WORD_W-1:0] word_out
);

    // Byte-wise select between message byte, marker byte and zero.
    always_comb begin
        word_out = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < n) begin
                word_out[(3 - b) * 8 +: 8] = word[(3 - b) * 8 +: 8];
            end else if (pad_en && (3'(b) == n)) begin
                word_out[(3 - b) * 8 +: 8] = SHA256_PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 padder: packs 32-bit message words into 512-bit blocks, appends the
// 0x80 marker, zero fill and 64-bit bit length, and emits blocks over valid/ready.
// Optional build macro SHA256_PADDER_PROTO_CHK_EN adds the proto_err output,
// flagging malformed in_bytes values on accepted words.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int CNT_W = 61
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SHA256_WORD_W-1:0]  in_data,
    input  logic                      in_last,
    input  logic [2:0]                in_bytes,
    output logic                      block_valid,
    input  logic                      block_ready,
    output logic [SHA256_BLOCK_W-1:0] block,
    output logic                      block_first,
    output logic                      block_last
`ifdef SHA256_PADDER_PROTO_CHK_EN
    ,
    output logic                      proto_err
`endif
);

    state_t                    state_q, state_d;
    logic [3:0]                widx_q, widx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      first_q, first_d;
    logic                      pend_q, pend_d;
    logic                      pend80_q, pend80_d;
    logic [SHA256_BLOCK_W-1:0] block_q, block_d;
    logic                      block_first_q, block_first_d;
    logic                      block_last_q, block_last_d;

    logic                      accept;
    logic [2:0]                n_eff;
    logic [6:0]                pos;
    logic [CNT_W-1:0]          cnt_inc;
    logic [SHA256_LEN_W-1:0]   len_new;
    logic [SHA256_LEN_W-1:0]   len_held;
    logic [SHA256_WORD_W-1:0]  pad_out;

    assign accept   = (state_q == FILL) && in_valid;
    assign n_eff    = in_last ? clamp_bytes(in_bytes) : 3'd4;
    assign pos      = {1'b0, widx_q, 2'b00} + {4'b0000, n_eff};
    assign cnt_inc  = cnt_q + CNT_W'(n_eff);
    assign len_new  = SHA256_LEN_W'({cnt_inc, 3'b000});
    assign len_held = SHA256_LEN_W'({cnt_q, 3'b000});

    sha256_pad_word u_pad_word (
        .word     (in_data),
        .n        (n_eff),
        .pad_en   (in_last),
        .word_out (pad_out)
    );

    // Next-state logic for the fill/emit FSM, block register, word index and byte count.
    always_comb begin
        state_d       = state_q;
        widx_d        = widx_q;
        cnt_d         = cnt_q;
        first_d       = first_q;
        pend_d        = pend_q;
        pend80_d      = pend80_q;
        block_d       = block_q;
        block_first_d = block_first_q;
        block_last_d  = block_last_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    cnt_d         = cnt_inc;
                    block_first_d = first_q;
                    for (int i = 0; i < SHA256_BLOCK_WORDS; i++) begin
                        if (4'(i) == widx_q) begin
                            block_d[(15 - i) * 32 +: 32] = pad_out;
                        end else if (in_last && (4'(i) > widx_q)) begin
                            if ((n_eff == 3'd4) && (4'(i) == widx_q + 4'd1)) begin
                                block_d[(15 - i) * 32 +: 32] = {SHA256_PAD_BYTE, 24'h0};
                            end else begin
                                block_d[(15 - i) * 32 +: 32] = '0;
                            end
                        end
                    end
                    if (in_last) begin
                        state_d = EMIT;
                        if (pos <= 7'd55) begin
                            block_d[SHA256_LEN_W-1:0] = len_new;
                            block_last_d = 1'b1;
                            pend_d       = 1'b0;
                            pend80_d     = 1'b0;
                        end else begin
                            block_last_d = 1'b0;
                            pend_d       = 1'b1;
                            pend80_d     = (pos == 7'd64);
                        end
                    end else begin
                        block_last_d = 1'b0;
                        pend_d       = 1'b0;
                        pend80_d     = 1'b0;
                        if (widx_q == 4'd15) begin
                            state_d = EMIT;
                        end else begin
                            widx_d = widx_q + 4'd1;
                        end
                    end
                end
            end
            EMIT: begin
                if (block_ready) begin
                    if (pend_q) begin
                        block_d = '0;
                        if (pend80_q) begin
                            block_d[SHA256_BLOCK_W-1 -: 32] = {SHA256_PAD_BYTE, 24'h0};
                        end
                        block_d[SHA256_LEN_W-1:0] = len_held;
                        block_first_d = 1'b0;
                        block_last_d  = 1'b1;
                        pend_d        = 1'b0;
                        pend80_d      = 1'b0;
                        first_d       = 1'b0;
                        state_d       = EMIT_LEN;
                    end else begin
                        state_d = FILL;
                        widx_d  = 4'd0;
                        if (block_last_q) begin
                            first_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            first_d = 1'b0;
                        end
                    end
                end
            end
            EMIT_LEN: begin
                if (block_ready) begin
                    state_d = FILL;
                    widx_d  = 4'd0;
                    first_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State, datapath and registered block outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FILL;
            widx_q        <= 4'd0;
            cnt_q         <= '0;
            first_q       <= 1'b1;
            pend_q        <= 1'b0;
            pend80_q      <= 1'b0;
            block_q       <= '0;
            block_first_q <= 1'b0;
            block_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            widx_q        <= widx_d;
            cnt_q         <= cnt_d;
            first_q       <= first_d;
            pend_q        <= pend_d;
            pend80_q      <= pend80_d;
            block_q       <= block_d;
            block_first_q <= block_first_d;
            block_last_q  <= block_last_d;
        end
    end

    assign in_ready    = (state_q == FILL);
    assign block_valid = (state_q != FILL);
    assign block       = block_q;
    assign block_first = block_first_q;
    assign block_last  = block_last_q;

`ifdef SHA256_PADDER_PROTO_CHK_EN
    logic proto_err_q, proto_err_d;

    assign proto_err_d = accept && ((!in_last && (in_bytes != 3'd4)) || (in_bytes > 3'd4));

    // One-cycle pulse after a word arrives with an illegal byte count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
`endif

endmodule
